// File: rtl/spi_master_xw.sv
// spi_master_xw: bus-mapped SPI master with runtime CPOL/CPHA, 8..32-bit
// transfers sized from wstrb, and NUM_CS software-driven chip selects.
// Optional feature macro: SPI_LSB_FIRST_EN (adds LSB-first shifting, ctrl bit 10).
module spi_master_xw #(
    parameter int unsigned NUM_CS    = 1,
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned DIV_W     = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ctrl,
    input  logic              valid,
    output logic              ready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic [31:0]       rdata,
    input  logic [DIV_W-1:0]  div,
    output logic [NUM_CS-1:0] cen,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam logic [1:0] MAX_IDX = 2'(MAX_BYTES - 1);

    typedef enum logic [1:0] {IDLE, XFER, FIN, DONE} state_t;

    state_t              state_q;
    logic                ready_q;
    logic [31:0]         rdata_q;
    logic [NUM_CS-1:0]   cen_q;
    logic [NUM_CS-1:0]   cs_en_q;
    logic                sclk_q;
    logic                mosi_q;
    logic                cpol_q;
    logic                cpha_q;
    logic [31:0]         sh_q;
    logic [31:0]         rx_q;
    logic [5:0]          nbits_q;
    logic [DIV_W-1:0]    h_q;
    logic [DIV_W-1:0]    hcnt_q;
    logic [6:0]          edge_q;

    logic                lsb;
`ifdef SPI_LSB_FIRST_EN
    logic                lsb_q;
    assign lsb = lsb_q;
`else
    assign lsb = 1'b0;
`endif

    logic [1:0]          lane_hi;
    logic [5:0]          nbits_d;
    logic [31:0]         mask_d;
    logic [31:0]         sh_d;
    logic                load_bit_d;
    logic [31:0]         load_sh_d;
    logic                tx_bit_d;
    logic [31:0]         tx_next_d;
    logic [31:0]         rx_next_d;
    logic [DIV_W-1:0]    h_d;
    logic                toggle_d;
    logic                sample_d;
    logic                last_edge_d;
    logic [31:0]         ctrl_rd;

    // Transfer sizing and shifter preload from the incoming access.
    always_comb begin
        lane_hi = 2'd0;
        if (wstrb[3])      lane_hi = 2'd3;
        else if (wstrb[2]) lane_hi = 2'd2;
        else if (wstrb[1]) lane_hi = 2'd1;
        if (lane_hi > MAX_IDX) lane_hi = MAX_IDX;
        nbits_d    = {1'b0, lane_hi, 3'b000} + 6'd8;
        mask_d     = 32'hFFFF_FFFF >> (6'd32 - nbits_d);
        sh_d       = lsb ? (wdata & mask_d) : (wdata << (6'd32 - nbits_d));
        load_bit_d = lsb ? sh_d[0] : sh_d[31];
        load_sh_d  = lsb ? (sh_d >> 1) : (sh_d << 1);
        h_d        = (div == '0) ? DIV_W'(1) : div;
    end

    // Per-edge shift/sample values and half-period bookkeeping during XFER.
    always_comb begin
        tx_bit_d    = lsb ? sh_q[0] : sh_q[31];
        tx_next_d   = lsb ? (sh_q >> 1) : (sh_q << 1);
        rx_next_d   = lsb ? ((rx_q >> 1) | (32'(miso) << (nbits_q - 6'd1)))
                          : {rx_q[30:0], miso};
        toggle_d    = (hcnt_q == h_q - DIV_W'(1));
        // Sampling happens on leading edges in CPHA=0, trailing edges in CPHA=1.
        sample_d    = (sclk_q == cpol_q) ^ cpha_q;
        last_edge_d = (edge_q == {nbits_q, 1'b0} - 7'd1);
    end

    // Control/status read image.
    always_comb begin
        ctrl_rd             = '0;
        ctrl_rd[NUM_CS-1:0] = cs_en_q;
        ctrl_rd[8]          = cpol_q;
        ctrl_rd[9]          = cpha_q;
        ctrl_rd[10]         = lsb;
        ctrl_rd[31]         = (state_q != IDLE);
    end

    // Main FSM with registered bus and SPI outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
            cen_q   <= '1;
            cs_en_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            sh_q    <= '0;
            rx_q    <= '0;
            nbits_q <= 6'd8;
            h_q     <= DIV_W'(1);
            hcnt_q  <= '0;
            edge_q  <= '0;
`ifdef SPI_LSB_FIRST_EN
            lsb_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    sclk_q <= cpol_q;
                    if (valid) begin
                        if (!ctrl) begin
                            rdata_q <= ctrl_rd;
                            if (wstrb[0]) begin
                                cs_en_q <= wdata[NUM_CS-1:0];
                                cen_q   <= ~wdata[NUM_CS-1:0];
                            end
                            if (wstrb[1]) begin
                                cpol_q <= wdata[8];
                                cpha_q <= wdata[9];
`ifdef SPI_LSB_FIRST_EN
                                lsb_q  <= wdata[10];
`endif
                            end
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end else if (wstrb == 4'b0000) begin
                            rdata_q <= rx_q;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            nbits_q <= nbits_d;
                            h_q     <= h_d;
                            hcnt_q  <= '0;
                            edge_q  <= '0;
                            rx_q    <= '0;
                            // CPHA=0 needs the first bit on mosi before the first edge.
                            if (!cpha_q) begin
                                mosi_q <= load_bit_d;
                                sh_q   <= load_sh_d;
                            end else begin
                                sh_q   <= sh_d;
                            end
                            state_q <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (toggle_d) begin
                        hcnt_q <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 7'd1;
                        if (sample_d) begin
                            rx_q <= rx_next_d;
                        end else begin
                            mosi_q <= tx_bit_d;
                            sh_q   <= tx_next_d;
                        end
                        if (last_edge_d) state_q <= FIN;
                    end else begin
                        hcnt_q <= hcnt_q + DIV_W'(1);
                    end
                end
                FIN: begin
                    rdata_q <= rx_q;
                    ready_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    ready_q <= 1'b0;
                    sclk_q  <= cpol_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign cen   = cen_q;
    assign sclk  = sclk_q;
    assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_xw.sv
// Self-checking bench for spi_master_xw: table of directed transfers plus
// hand sequences for stalled control access and mid-transfer reset.
module tb_spi_master_xw;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ctrl;
    logic        valid;
    logic        ready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [15:0] div;
    logic [1:0]  cen;
    logic        sclk;
    logic        mosi;
    logic        miso;
    int          sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Passive slave monitor state.
    logic        mon_en = 1'b0;
    logic        cur_cpol = 1'b0;
    logic        cur_cpha = 1'b0;
    int          mon_pulses = 0;
    logic [63:0] mon_cap = '0;

    always #5 clk = ~clk;

    assign miso = (sel == 0) ? mosi : (sel == 1) ? 1'b1 : 1'b0;

    spi_master_xw #(.NUM_CS(2), .MAX_BYTES(4), .DIV_W(16)) dut (
        .clk(clk), .resetn(resetn), .ctrl(ctrl), .valid(valid), .ready(ready),
        .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .div(div), .cen(cen),
        .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    // Count leading edges and capture mosi where a slave of this mode samples.
    always @(sclk) begin
        if (mon_en) begin
            if (sclk != cur_cpol) mon_pulses = mon_pulses + 1;
            if ((sclk != cur_cpol) ^ cur_cpha) mon_cap = {mon_cap[62:0], mosi};
        end
    end

    typedef struct {
        logic        cpol;
        logic        cpha;
        logic [15:0] div;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          sel;
        int          nbits;
        int          lat;
        logic [31:0] tx;
        logic [31:0] rx;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic bus(input logic c, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd, output int lat);
        @(negedge clk);
        ctrl = c; wstrb = s; wdata = d; valid = 1'b1;
        @(posedge clk);
        lat = -1;
        rd  = '0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (ready) begin
                lat = k;
                rd  = rdata;
                break;
            end
        end
        valid = 1'b0;
        chk("bus_ready_seen", 32'(lat > 0), 32'd1);
    endtask

    task automatic check_xfer(input vec_t v, input string tag);
        logic [31:0] rd;
        int          lat;
        int          p0;
        logic [63:0] m;
        div = v.div; sel = v.sel;
        cur_cpol = v.cpol; cur_cpha = v.cpha;
        p0 = mon_pulses;
        mon_en = 1'b1;
        bus(1'b1, v.wstrb, v.wdata, rd, lat);
        mon_en = 1'b0;
        m = (64'd1 << v.nbits) - 64'd1;
        chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
        chk({tag, "_pulses"}, 32'(mon_pulses - p0), 32'(v.nbits));
        chk({tag, "_mosi_bits"}, 32'(mon_cap & m), v.tx);
        chk({tag, "_rdata_at_ready"}, rd, v.rx);
        chk({tag, "_sclk_end"}, 32'(sclk), 32'(v.cpol));
        bus(1'b1, 4'b0000, 32'h0, rd, lat);
        chk({tag, "_rx_read"}, rd, v.rx);
        chk({tag, "_read_latency"}, 32'(lat), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          cnt;
        int          first_r;
        int          second_r;
        int          stray;
        vec_t        v;

        vt[0] = '{cpol:1'b0, cpha:1'b0, div:16'd2, wstrb:4'b0001, wdata:32'h0000_00A5,
                  sel:0, nbits:8,  lat:34, tx:32'h0000_00A5, rx:32'h0000_00A5};
        vt[1] = '{cpol:1'b1, cpha:1'b1, div:16'd0, wstrb:4'b1111, wdata:32'h1234_5678,
                  sel:0, nbits:32, lat:66, tx:32'h1234_5678, rx:32'h1234_5678};
        vt[2] = '{cpol:1'b0, cpha:1'b0, div:16'd1, wstrb:4'b0100, wdata:32'h00AB_0000,
                  sel:1, nbits:24, lat:50, tx:32'h00AB_0000, rx:32'h00FF_FFFF};
        vt[3] = '{cpol:1'b0, cpha:1'b1, div:16'd3, wstrb:4'b0010, wdata:32'hDEAD_C35A,
                  sel:0, nbits:16, lat:98, tx:32'h0000_C35A, rx:32'h0000_C35A};
        vt[4] = '{cpol:1'b1, cpha:1'b0, div:16'd1, wstrb:4'b1000, wdata:32'h8000_0001,
                  sel:2, nbits:32, lat:66, tx:32'h8000_0001, rx:32'h0000_0000};

        resetn = 1'b0; ctrl = 1'b0; valid = 1'b0; wdata = '0; wstrb = '0;
        div = 16'd2; sel = 0;
        repeat (3) @(negedge clk);
        chk("reset_cen", 32'(cen), 32'h3);
        chk("reset_sclk", 32'(sclk), 32'h0);
        chk("reset_mosi", 32'(mosi), 32'h0);
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        resetn = 1'b1;

        bus(1'b0, 4'b0000, 32'h0, rd, lat);
        chk("ctrl_read_reset", rd, 32'h0);
        chk("ctrl_read_latency", 32'(lat), 32'd1);
        bus(1'b1, 4'b0000, 32'h0, rd, lat);
        chk("data_read_reset", rd, 32'h0);
        chk("data_read_latency", 32'(lat), 32'd1);

        // Both chip selects together, then read back.
        bus(1'b0, 4'b0001, 32'h0000_0003, rd, lat);
        chk("ctrl_write_latency", 32'(lat), 32'd1);
        @(negedge clk);
        chk("cen_both", 32'(cen), 32'h0);
        bus(1'b0, 4'b0000, 32'h0, rd, lat);
        chk("ctrl_read_cs", rd, 32'h0000_0003);

        for (int i = 0; i < 5; i++) begin
            v = vt[i];
            bus(1'b0, 4'b0011, {22'h0, v.cpha, v.cpol, 8'h01}, rd, lat);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_sclk_idle", i), 32'(sclk), 32'(v.cpol));
            chk($sformatf("v%0d_cen", i), 32'(cen), 32'h2);
            check_xfer(v, $sformatf("v%0d", i));
        end

        // Control write issued mid-transfer: stalled until the transfer's DONE.
        bus(1'b0, 4'b0011, 32'h0000_0001, rd, lat);
        div = 16'd2; sel = 0;
        @(negedge clk);
        ctrl = 1'b1; wstrb = 4'b0001; wdata = 32'h0000_003C; valid = 1'b1;
        @(posedge clk);
        cnt = 0; first_r = -1; second_r = -1;
        @(negedge clk); cnt++;
        valid = 1'b0;
        repeat (3) begin @(negedge clk); cnt++; end
        ctrl = 1'b0; wstrb = 4'b0010; wdata = 32'h0000_0200; valid = 1'b1;
        while (second_r < 0 && cnt < 300) begin
            @(negedge clk); cnt++;
            if (ready) begin
                if (first_r < 0) first_r = cnt;
                else second_r = cnt;
            end
        end
        valid = 1'b0;
        chk("stall_xfer_ready_cycle", 32'(first_r), 32'd34);
        chk("stall_ctrl_ready_cycle", 32'(second_r), 32'd36);
        bus(1'b0, 4'b0000, 32'h0, rd, lat);
        chk("stall_ctrl_applied", rd, 32'h0000_0201);
        v = '{cpol:1'b0, cpha:1'b1, div:16'd1, wstrb:4'b0001, wdata:32'h0000_0096,
              sel:0, nbits:8, lat:18, tx:32'h0000_0096, rx:32'h0000_0096};
        check_xfer(v, "cpha1_after_stall");

        // Reset in the middle of a transfer aborts without a ready pulse.
        div = 16'd4;
        @(negedge clk);
        ctrl = 1'b1; wstrb = 4'b1111; wdata = 32'hF0F0_F0F0; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("abort_cen", 32'(cen), 32'h3);
        chk("abort_sclk", 32'(sclk), 32'h0);
        chk("abort_ready", 32'(ready), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        stray = 0;
        repeat (300) begin
            @(negedge clk);
            if (ready) stray++;
        end
        chk("abort_no_ready", 32'(stray), 32'd0);
        bus(1'b0, 4'b0000, 32'h0, rd, lat);
        chk("abort_ctrl_cleared", rd, 32'h0);

        // Bit 10 is LSB-first select only when the feature is built in.
        bus(1'b0, 4'b0010, 32'h0000_0400, rd, lat);
        bus(1'b0, 4'b0000, 32'h0, rd, lat);
`ifdef SPI_LSB_FIRST_EN
        chk("lsb_bit_readback", rd, 32'h0000_0400);
        v = '{cpol:1'b0, cpha:1'b0, div:16'd1, wstrb:4'b0001, wdata:32'h0000_0001,
              sel:0, nbits:8, lat:18, tx:32'h0000_0080, rx:32'h0000_0001};
        check_xfer(v, "lsb_first");
`else
        chk("lsb_bit_readback", rd, 32'h0000_0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
